if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC register and a variable-latency instruction memory port. It owns the fetch PC and issues one request at a time using a req/gnt handshake. It collects the rvalid response, presents the instruction to the IF/ID stage under stall backpressure, and applies branch redirects from ID and EXE. Any response fetched on a squashed path is discarded.

Parameters:
RESET_PC, 64'h0, fetch address loaded on reset
ADDR_W, 64, PC/address width
INST_W, 32, instruction width

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-low reset (0 = reset)
stall  input  1  IF/ID not accepting; holds presented instruction
npc_sel_id  input  1  redirect request from ID
npc_target_id  input  ADDR_W  ID redirect target
npc_sel_exe  input  1  redirect request from EXE
npc_target_exe  input  ADDR_W  EXE redirect target
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  fetch address
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid (exactly one per granted request)
imem_rdata  input  INST_W  response instruction
valid_if  output  1  if_inst/if_pc valid to IF/ID
if_pc  output  ADDR_W  PC of presented instruction
if_inst  output  INST_W  presented instruction
busy  output  1  request outstanding (state WAIT or DROP)

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC, valid_if=0, if_pc=RESET_PC, if_inst=0, busy=0.
  - Reset mid-transaction abandons it. A late rvalid arriving after reset is ignored, because IDLE/REQ ignore rvalid.
- Redirect select: npc_sel_exe has priority over npc_sel_id. target = exe ? npc_target_exe : npc_target_id; redir = npc_sel_exe | npc_sel_id. target[1:0] is forced to 0.
- Only one request is outstanding at a time. imem_addr = pc whenever imem_req=1.
- IDLE: outputs idle. Next cycle goes to REQ. A redir in IDLE loads pc=target.
- REQ: imem_req=1.
  - gnt and no redir -> WAIT.
  - gnt and redir -> pc=target, go to DROP (the granted request is stale).
  - no gnt and redir -> pc=target, stay in REQ; the new address is driven the next cycle.
- WAIT: imem_req=0, busy=1.
  - redir -> pc=target, go to DROP. This applies even if rvalid arrives in the same cycle; that data is discarded and the next state is REQ.
  - rvalid and no redir -> latch if_inst=rdata, if_pc=pc, pc=pc+4, valid_if=1 from the next cycle, go to HOLD.
- DROP: imem_req=0, busy=1, valid_if=0.
  - Waits for rvalid, discards it, then goes to REQ with the current pc.
  - A further redir in DROP updates pc only.
- HOLD: valid_if=1.
  - Consumed on any cycle with stall=0 and no redir -> valid_if=0 next cycle, go to REQ.
  - stall=1 -> all outputs held stable.
  - redir (with or without stall) -> valid_if=0, pc=target, go to REQ.
- Minimum latency is 2 cycles from imem_req to valid_if, when gnt is in the REQ cycle and rvalid arrives the following cycle. Sustained throughput is one instruction per 3 cycles.
- pc+4 wraps modulo 2^ADDR_W; no overflow flag.
- valid_if never asserts for an instruction whose request preceded a redirect.

Optional Feature:
- Macro IF_FETCH_PERF_EN:
  - When defined: adds outputs perf_fetch_cnt [31:0] (increments per valid_if handoff, i.e. HOLD exit with stall=0 and no redir) and perf_drop_cnt [31:0] (increments per response discarded in DROP or in the WAIT redir+rvalid case). Both are cleared on reset and wrap at 2^32.
  - When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0, gnt tied 1, rvalid 1 cycle after gnt, stall=0 -> imem_addr sequence 0,4,8; valid_if pulses with if_pc 0,4,8 and if_inst matching the memory model.
- gnt delayed 3 cycles in REQ -> imem_req and imem_addr=0 stable for 4 cycles; exactly one handoff with if_pc=0.
- stall=1 for 5 cycles during HOLD (if_pc=4) -> valid_if, if_pc, if_inst stable; no imem_req until stall drops; next imem_addr=8.
- npc_sel_exe=1, target 0x100 while WAIT (fetch of 0x8); rvalid 2 cycles later -> response dropped, no valid_if for 0x8, next imem_addr=0x100.
- npc_sel_id=1 (0x200) and npc_sel_exe=1 (0x300) in the same cycle in REQ without gnt -> next imem_addr=0x300.
- rst=0 asserted in WAIT with rvalid arriving the next cycle -> outputs at reset values, rvalid ignored, imem_addr=RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Purpose  : Instruction-fetch sequencer. Owns the fetch PC, issues one
//            instruction-memory request at a time over a req/gnt handshake,
//            collects the rvalid response and presents it to IF/ID under
//            stall backpressure. Branch redirects from ID and EXE (EXE wins)
//            reload the PC, and any response already in flight on the
//            squashed path is discarded.
// Ports    : clk, rst (sync, active-low)       - clock / reset
//            stall                             - IF/ID backpressure
//            npc_sel_id/exe, npc_target_id/exe - redirect requests/targets
//            imem_req/addr/gnt/rvalid/rdata    - instruction memory port
//            valid_if, if_pc, if_inst          - presented instruction
//            busy                              - request outstanding
//            perf_fetch_cnt, perf_drop_cnt     - only with IF_FETCH_PERF_EN
// Options  : IF_FETCH_PERF_EN - adds handoff / discarded-response counters
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              npc_sel_id,
    input  logic [ADDR_W-1:0] npc_target_id,
    input  logic              npc_sel_exe,
    input  logic [ADDR_W-1:0] npc_target_exe,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              valid_if,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              busy
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid_if;
    logic [ADDR_W-1:0] r_if_pc;
    logic [INST_W-1:0] r_if_inst;

    logic              w_redir;
    logic [ADDR_W-1:0] w_target;

    // EXE redirect is older in program order, so it overrides ID.
    // Targets are word aligned; the low two bits are discarded.
    assign w_redir  = npc_sel_exe | npc_sel_id;
    assign w_target = (npc_sel_exe ? npc_target_exe : npc_target_id) & ~ADDR_W'(3);

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_drop_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_valid_if <= 1'b0;
            r_if_pc    <= RESET_PC;
            r_if_inst  <= '0;
`ifdef IF_FETCH_PERF_EN
            r_fetch_cnt <= '0;
            r_drop_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_redir) r_pc <= w_target;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    // A redirect in the grant cycle makes the accepted
                    // request stale; its response must be thrown away.
                    if (w_redir) r_pc <= w_target;
                    if (imem_gnt) r_state <= w_redir ? S_DROP : S_WAIT;
                end
                S_WAIT: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                        if (imem_rvalid) begin
                            r_state <= S_REQ;
`ifdef IF_FETCH_PERF_EN
                            r_drop_cnt <= r_drop_cnt + 32'd1;
`endif
                        end else begin
                            r_state <= S_DROP;
                        end
                    end else if (imem_rvalid) begin
                        r_if_inst  <= imem_rdata;
                        r_if_pc    <= r_pc;
                        r_pc       <= r_pc + ADDR_W'(4);
                        r_valid_if <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (w_redir) r_pc <= w_target;
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
`ifdef IF_FETCH_PERF_EN
                        r_drop_cnt <= r_drop_cnt + 32'd1;
`endif
                    end
                end
                S_HOLD: begin
                    if (w_redir) begin
                        r_valid_if <= 1'b0;
                        r_pc       <= w_target;
                        r_state    <= S_REQ;
                    end else if (!stall) begin
                        r_valid_if <= 1'b0;
                        r_state    <= S_REQ;
`ifdef IF_FETCH_PERF_EN
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
`endif
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_valid_if <= 1'b0;
                end
            endcase
        end
    end

    // Request and busy decode directly from the registered state.
    assign imem_req  = (r_state == S_REQ);
    assign busy      = (r_state == S_WAIT) || (r_state == S_DROP);
    assign imem_addr = r_pc;
    assign valid_if  = r_valid_if;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;

`ifdef IF_FETCH_PERF_EN
    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_drop_cnt  = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Purpose  : Self-checking bench for if_fetch_ctrl. A transaction-level
//            model (fetch PC, one outstanding-request flag, stale flag,
//            presenting flag) predicts the outputs every cycle; a memory
//            model answers requests with address-derived instructions.
//            Directed scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    localparam int          ADDR_W   = 64;
    localparam int          INST_W   = 32;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, stall, npc_sel_id, npc_sel_exe;
    logic [ADDR_W-1:0] npc_target_id, npc_target_exe;
    logic              imem_req, imem_gnt, imem_rvalid;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              valid_if, busy;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]       perf_fetch_cnt, perf_drop_cnt;
`endif

    if_fetch_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .npc_sel_id(npc_sel_id), .npc_target_id(npc_target_id),
        .npc_sel_exe(npc_sel_exe), .npc_target_exe(npc_target_exe),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .valid_if(valid_if), .if_pc(if_pc), .if_inst(if_inst), .busy(busy)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs set by the directed / random sections.
    logic        tb_rst = 1'b0, tb_stall = 1'b0, tb_sel_id = 1'b0, tb_sel_exe = 1'b0;
    logic [63:0] tb_tid = '0, tb_texe = '0;
    int          gnt_delay = 0, rv_delay = 1;
    bit          rand_mem = 1'b0;

    // Memory model.
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0, req_len = 0;
    logic [63:0] mem_addr = '0;
    logic [63:0] grants[$];
    int          gnt_lens[$];

    // Behavioural fetch model.
    logic [63:0] m_pc = RESET_PC, m_hpc = RESET_PC;
    logic [31:0] m_hinst = '0, m_fetch = '0, m_drop = '0;
    bit          m_started = 1'b0, m_out = 1'b0, m_stale = 1'b0, m_pres = 1'b0;
    logic [63:0] handoffs[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic model_update(input bit g, input bit rv, input logic [31:0] rd);
        bit          redir;
        logic [63:0] tgt;
        if (!tb_rst) begin
            m_pc = RESET_PC; m_hpc = RESET_PC; m_hinst = '0;
            m_started = 0; m_out = 0; m_stale = 0; m_pres = 0;
            m_fetch = '0; m_drop = '0;
        end else begin
            redir = tb_sel_id | tb_sel_exe;
            tgt   = (tb_sel_exe ? tb_texe : tb_tid) & ~64'h3;
            if (!m_started) begin
                m_started = 1;
                if (redir) m_pc = tgt;
            end else if (m_pres) begin
                if (redir) begin
                    m_pres = 0; m_pc = tgt;
                end else if (!tb_stall) begin
                    m_pres = 0; m_fetch++; handoffs.push_back(m_hpc);
                end
            end else if (m_out) begin
                if (redir) begin m_pc = tgt; m_stale = 1; end
                if (rv) begin
                    m_out = 0;
                    if (m_stale) begin
                        m_drop++; m_stale = 0;
                    end else begin
                        m_hpc = m_pc; m_hinst = rd; m_pc = m_pc + 64'd4; m_pres = 1;
                    end
                end
            end else begin
                if (redir) m_pc = tgt;
                if (g) begin m_out = 1; m_stale = redir; end
            end
        end
    endtask

    // One clock: compare at negedge, drive inputs, advance models,
    // then return just after the posedge so callers see the new state.
    task automatic step();
        bit m_req, g, rv;
        @(negedge clk);
        m_req = m_started && !m_out && !m_pres;
        check("imem_req", imem_req, m_req);
        check("busy", busy, m_out);
        check("valid_if", valid_if, m_pres);
        if (m_req || !m_started) check("imem_addr", imem_addr, m_pc);
        if (m_pres || !m_started) begin
            check("if_pc", if_pc, m_hpc);
            check("if_inst", if_inst, m_hinst);
        end
`ifdef IF_FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        check("perf_drop_cnt", perf_drop_cnt, m_drop);
`endif
        rv = mem_pend && (mem_cnt == 0);
        g  = tb_rst && imem_req && !mem_pend && (req_len >= gnt_delay);
        rst            = tb_rst;
        stall          = tb_stall;
        npc_sel_id     = tb_sel_id;
        npc_target_id  = tb_tid;
        npc_sel_exe    = tb_sel_exe;
        npc_target_exe = tb_texe;
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rv ? inst_of(mem_addr) : $urandom;
        model_update(g, rv, imem_rdata);
        if (rv) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (g) begin
            mem_pend = 1; mem_addr = imem_addr; mem_cnt = rv_delay - 1;
            grants.push_back(imem_addr); gnt_lens.push_back(req_len + 1); req_len = 0;
            if (rand_mem) begin
                gnt_delay = $urandom_range(0, 3); rv_delay = $urandom_range(1, 4);
            end
        end else if (imem_req && tb_rst) req_len++;
        else req_len = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        tb_rst = 0; tb_stall = 0; tb_sel_id = 0; tb_sel_exe = 0;
        repeat (3) step();
        grants.delete(); gnt_lens.delete(); handoffs.delete();
        req_len = 0;
        tb_rst = 1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, imem_req, 0);
        check({tag, "_addr"}, imem_addr, RESET_PC);
        check({tag, "_valid"}, valid_if, 0);
        check({tag, "_pc"}, if_pc, RESET_PC);
        check({tag, "_inst"}, if_inst, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_until_grant(input string tag);
        int n = 0;
        while (grants.size() == 0 && n < 20) begin step(); n++; end
        check({tag, "_grant_seen"}, grants.size() > 0, 1);
    endtask

    initial begin
        int n, cnt;
        rst = 0; stall = 0; npc_sel_id = 0; npc_sel_exe = 0;
        npc_target_id = '0; npc_target_exe = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;

        // Basic back-to-back fetch with minimum latency.
        gnt_delay = 0; rv_delay = 1;
        reset_dut();
        check_reset_vals("rst0");
        step();
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, 64'h0);
        step(); step();
        check("t1_lat_valid", valid_if, 1);
        check("t1_lat_pc", if_pc, 64'h0);
        check("t1_lat_inst", if_inst, 32'h1357_9BDF);
        repeat (8) step();
        check("t1_n", (grants.size() >= 3) && (handoffs.size() >= 3), 1);
        if (grants.size() >= 3 && handoffs.size() >= 3) begin
            check("t1_g0", grants[0], 64'h0); check("t1_g1", grants[1], 64'h4);
            check("t1_g2", grants[2], 64'h8);
            check("t1_h0", handoffs[0], 64'h0); check("t1_h1", handoffs[1], 64'h4);
            check("t1_h2", handoffs[2], 64'h8);
        end

        // Grant held off for 3 cycles.
        gnt_delay = 3;
        reset_dut();
        repeat (14) step();
        check("t2_n", gnt_lens.size() > 0, 1);
        if (gnt_lens.size() > 0) begin
            check("t2_len", gnt_lens[0], 4);
            check("t2_addr", grants[0], 64'h0);
        end
        cnt = 0;
        foreach (handoffs[i]) if (handoffs[i] == 64'h0) cnt++;
        check("t2_one_handoff", cnt, 1);

        // Stall for 5 cycles while presenting PC 4.
        gnt_delay = 0; rv_delay = 1;
        reset_dut();
        n = 0;
        while (!(valid_if && if_pc == 64'h4) && n < 20) begin step(); n++; end
        check("t3_found", valid_if && if_pc == 64'h4, 1);
        tb_stall = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", valid_if, 1);
            check("t3_hold_pc", if_pc, 64'h4);
            check("t3_hold_noreq", imem_req, 0);
        end
        tb_stall = 0;
        grants.delete();
        run_until_grant("t3");
        if (grants.size() > 0) check("t3_next", grants[0], 64'h8);

        // EXE redirect while waiting on the fetch of 0x8.
        rv_delay = 2;
        reset_dut();
        n = 0;
        while (!(busy && imem_addr == 64'h8) && n < 30) begin step(); n++; end
        check("t4_found", busy && imem_addr == 64'h8, 1);
        tb_sel_exe = 1; tb_texe = 64'h100;
        step();
        tb_sel_exe = 0;
        check("t4_drop_busy", busy, 1);
        check("t4_drop_novalid", valid_if, 0);
        grants.delete();
        run_until_grant("t4");
        if (grants.size() > 0) check("t4_next", grants[0], 64'h100);
        cnt = 0;
        foreach (handoffs[i]) if (handoffs[i] == 64'h8) cnt++;
        check("t4_no_8", cnt, 0);

        // ID and EXE redirect together in REQ without grant.
        gnt_delay = 5; rv_delay = 1;
        reset_dut();
        n = 0;
        while (!imem_req && n < 5) begin step(); n++; end
        tb_sel_id = 1; tb_tid = 64'h200; tb_sel_exe = 1; tb_texe = 64'h300;
        step();
        tb_sel_id = 0; tb_sel_exe = 0;
        check("t5_req", imem_req, 1);
        check("t5_addr", imem_addr, 64'h300);
        run_until_grant("t5");
        if (grants.size() > 0) check("t5_grant", grants[0], 64'h300);

        // Reset in WAIT, late rvalid arrives after reset.
        gnt_delay = 0; rv_delay = 2;
        reset_dut();
        n = 0;
        while (!busy && n < 10) begin step(); n++; end
        check("t6_found", busy, 1);
        tb_rst = 0;
        step();
        check_reset_vals("t6");
        tb_rst = 1;
        grants.delete();
        run_until_grant("t6");
        if (grants.size() > 0) check("t6_grant", grants[0], RESET_PC);

        // PC wrap at the top of the address space (redirect in IDLE).
        rv_delay = 1;
        reset_dut();
        tb_sel_id = 1; tb_tid = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        tb_sel_id = 0;
        n = 0;
        while (grants.size() < 2 && n < 20) begin step(); n++; end
        check("t7_n", grants.size() >= 2, 1);
        if (grants.size() >= 2) begin
            check("t7_g0", grants[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check("t7_g1", grants[1], 64'h0);
        end

        // Randomized traffic against the model.
        rand_mem = 1;
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            tb_rst     = ($urandom_range(0, 199) != 0);
            tb_stall   = ($urandom_range(0, 9) < 3);
            tb_sel_id  = ($urandom_range(0, 99) < 7);
            tb_sel_exe = ($urandom_range(0, 99) < 7);
            tb_tid     = ($urandom_range(0, 9) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                                      : {32'h0, $urandom};
            tb_texe    = ($urandom_range(0, 9) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                                      : {32'h0, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
